sdram_cmd_fifo: RTL and testbench
=================================

SDRAM_CMD_FIFO -- requirements
Module: sdram_cmd_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning instruction word width: 13 address + 2 bank + 16 data + 1 write-enable bit.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of entries; it SHALL be a power of two, minimum 4.
REQ-003 SHALL have parameter AF_MARGIN, default 2, meaning Almost_Full asserts when free entries are at or below this value.
REQ-004 Clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Wr_En  input  1  host push request.
REQ-007 Wr_Data  input  WIDTH  host instruction word: [31:19] row/column, [18:17] bank, [16:1] write data, [0] write enable (1 = write, 0 = read).
REQ-008 Full  output  1  no free entry.
REQ-009 Almost_Full  output  1  free entries are at or below AF_MARGIN.
REQ-010 Rd_En  input  1  pop strobe from the SDRAM controller.
REQ-011 Rd_Data  output  WIDTH  head-of-queue word, first-word-fall-through.
REQ-012 Empty  output  1  no valid entry.
REQ-013 Count  output  log2(DEPTH)+1  number of occupied entries, range 0..DEPTH.
REQ-014 Overflow  output  1  one-cycle pulse indicating a refused push.
REQ-015 Underflow  output  1  one-cycle pulse indicating a refused pop.

Function
REQ-016 A push SHALL be accepted on a rising edge iff Wr_En=1 and Full=0: the word is stored at the write pointer and the write pointer increments modulo DEPTH.
REQ-017 A pop SHALL be accepted on a rising edge iff Rd_En=1 and Empty=0: the read pointer increments modulo DEPTH.
REQ-018 Rd_Data SHALL equal the oldest stored word whenever Empty=0 (first-word-fall-through), with no read latency.
REQ-019 Rd_Data SHALL be all zeros whenever Empty=1.
REQ-020 A word pushed at edge N SHALL be visible on Rd_Data, with Empty=0, from edge N onward when the FIFO was empty before edge N.
REQ-021 Count SHALL be registered and update at the same edge as each accepted push or pop.
- push only: Count+1
- pop only: Count-1
- both, or neither: unchanged
REQ-022 Empty, Full and Almost_Full SHALL be registered.
- Empty=1 iff Count=0
- Full=1 iff Count=DEPTH
- Almost_Full=1 iff DEPTH-Count <= AF_MARGIN
REQ-023 Simultaneous push and pop with 0 < Count < DEPTH SHALL both be accepted, with Count unchanged.
REQ-024 Simultaneous push and pop when Empty=1: the push SHALL be accepted, the pop refused, and Underflow SHALL pulse.
REQ-025 Simultaneous push and pop when Full=1: the pop SHALL be accepted, the push refused (Full is evaluated before the edge), and Overflow SHALL pulse.
REQ-026 Wr_En=1 while Full=1 SHALL leave the contents unchanged and set Overflow=1 for exactly the following cycle.
REQ-027 Rd_En=1 while Empty=1 SHALL leave the pointers unchanged and set Underflow=1 for exactly the following cycle.
REQ-028 Pointers SHALL carry an extra wrap bit so that full and empty are unambiguous; wrap-around SHALL NOT corrupt ordering.
REQ-029 Words SHALL be delivered in strict push order with their bit fields unmodified.
REQ-030 A single-cycle Rd_En pulse SHALL pop exactly one word, matching the controller's one-cycle read-enable handshake.

Reset
REQ-031 Reset_n=0 SHALL immediately, without waiting for a clock edge, force:
- pointers and Count to 0
- Empty=1, Full=0, Almost_Full=0
- Overflow=0, Underflow=0
- Rd_Data to all zeros
REQ-032 Storage array contents SHALL NOT be reset.
REQ-033 Reset asserted mid-operation SHALL discard all queued words; pushes and pops presented while Reset_n=0 SHALL be ignored.
REQ-034 The first push SHALL be accepted on the first rising edge after Reset_n deasserts.

Verification
REQ-035 Reset, then push 0x0002_0003 -> after that edge Empty=0, Count=1, Rd_Data=0x0002_0003; pop once -> Empty=1, Rd_Data=0.
REQ-036 Push 16 words 0..15 with no pops -> Almost_Full=1 at Count=14, Full=1 at Count=16; a 17th push -> Overflow pulses for one cycle and Count stays 16; 16 pops return 0..15 in order.
REQ-037 Pop when Empty -> Underflow pulses for one cycle and Count stays 0; simultaneous push and pop when empty -> Count=1, Underflow pulses.
REQ-038 Hold Count=8 with simultaneous push and pop for 40 cycles (pointer wrap) -> Count stays 8 and output order matches a scoreboard.
REQ-039 With Count=5, assert Reset_n=0 between clock edges -> Empty=1 and Count=0 before the next edge; a post-reset push of 0xA5A5_A5A5 reads back correctly.

Source files
------------

// File: rtl/sdram_cmd_fifo_if.sv
// rtl/sdram_cmd_fifo_if.sv - host/controller handshake bundle for the SDRAM command FIFO
interface sdram_cmd_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) ();
  logic                       Wr_En;
  logic [WIDTH-1:0]           Wr_Data;
  logic                       Full;
  logic                       Almost_Full;
  logic                       Rd_En;
  logic [WIDTH-1:0]           Rd_Data;
  logic                       Empty;
  logic [$clog2(DEPTH):0]     Count;
  logic                       Overflow;
  logic                       Underflow;

  modport master (
    output Wr_En, Wr_Data, Rd_En,
    input  Full, Almost_Full, Rd_Data, Empty, Count, Overflow, Underflow
  );

  modport slave (
    input  Wr_En, Wr_Data, Rd_En,
    output Full, Almost_Full, Rd_Data, Empty, Count, Overflow, Underflow
  );
endinterface

// File: rtl/sdram_cmd_fifo.sv
// rtl/sdram_cmd_fifo.sv - first-word-fall-through instruction queue between host and SDRAM controller
module sdram_cmd_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  sdram_cmd_fifo_if.slave   fifo_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q, afull_q;
  logic             ovf_q, unf_q;
  logic             push, pop;

  // Acceptance uses the registered flags, so Full/Empty are judged before the edge.
  assign push = fifo_bus.Wr_En & ~full_q;
  assign pop  = fifo_bus.Rd_En & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    // The wrap bit keeps this difference distinct for 0 and DEPTH occupancy.
    count_d  = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (wr_ptr_d == rd_ptr_d);
      full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      afull_q  <= ((CW'(DEPTH) - count_d) <= CW'(AF_MARGIN));
      ovf_q    <= fifo_bus.Wr_En & full_q;
      unf_q    <= fifo_bus.Rd_En & empty_q;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (push && Reset_n) mem[wr_ptr_q[AW-1:0]] <= fifo_bus.Wr_Data;
  end

  assign fifo_bus.Rd_Data     = empty_q ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign fifo_bus.Empty       = empty_q;
  assign fifo_bus.Full        = full_q;
  assign fifo_bus.Almost_Full = afull_q;
  assign fifo_bus.Count       = count_q;
  assign fifo_bus.Overflow    = ovf_q;
  assign fifo_bus.Underflow   = unf_q;
endmodule

// File: tb/tb_sdram_cmd_fifo.sv
// tb/tb_sdram_cmd_fifo.sv - scoreboard bench for sdram_cmd_fifo
module tb_sdram_cmd_fifo;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mcnt = 0;
  logic [31:0] exp_q [$];

  sdram_cmd_fifo_if #(.WIDTH(32), .DEPTH(DEPTH)) bus ();

  sdram_cmd_fifo #(.WIDTH(32), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .fifo_bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must deliver the oldest outstanding word.
  always @(negedge Clk) begin
    if (Reset_n && bus.Rd_En && !bus.Empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%08h expected no pop", bus.Rd_Data);
      end else begin
        chk("rd_order", bus.Rd_Data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic we, input logic [31:0] wd, input logic re);
    logic push_ok, pop_ok, e_ovf, e_unf;
    bus.Wr_En   = we;
    bus.Wr_Data = wd;
    bus.Rd_En   = re;
    push_ok = we && (mcnt < DEPTH);
    pop_ok  = re && (mcnt > 0);
    e_ovf   = we && (mcnt == DEPTH);
    e_unf   = re && (mcnt == 0);
    if (push_ok) exp_q.push_back(wd);
    @(posedge Clk);
    #1;
    mcnt = mcnt + int'(push_ok) - int'(pop_ok);
    chk("count",       32'(bus.Count),       32'(mcnt));
    chk("empty",       32'(bus.Empty),       32'(mcnt == 0));
    chk("full",        32'(bus.Full),        32'(mcnt == DEPTH));
    chk("almost_full", 32'(bus.Almost_Full), 32'((DEPTH - mcnt) <= AFM));
    chk("overflow",    32'(bus.Overflow),    32'(e_ovf));
    chk("underflow",   32'(bus.Underflow),   32'(e_unf));
    if (mcnt == 0) chk("rd_data_zero", bus.Rd_Data, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Wr_En = 1'b0;
    bus.Wr_Data = '0;
    bus.Rd_En = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_empty",   32'(bus.Empty),       32'h1);
    chk("rst_count",   32'(bus.Count),       32'h0);
    chk("rst_full",    32'(bus.Full),        32'h0);
    chk("rst_afull",   32'(bus.Almost_Full), 32'h0);
    chk("rst_ovf",     32'(bus.Overflow),    32'h0);
    chk("rst_unf",     32'(bus.Underflow),   32'h0);
    chk("rst_rd_data", bus.Rd_Data,          32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // First push right after reset, visible on the same edge.
    cyc(1'b1, 32'h0002_0003, 1'b0);
    chk("fwft_data",  bus.Rd_Data,      32'h0002_0003);
    chk("fwft_count", 32'(bus.Count),   32'h1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("pop_empty", 32'(bus.Empty), 32'h1);

    // Fill to full, overflow once, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 32'(i), 1'b0);
      if (i == 12) chk("afull_at_13", 32'(bus.Almost_Full), 32'h0);
      if (i == 13) chk("afull_at_14", 32'(bus.Almost_Full), 32'h1);
    end
    chk("full_at_16", 32'(bus.Full), 32'h1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("ovf_pulse", 32'(bus.Overflow), 32'h1);
    chk("ovf_count", 32'(bus.Count),    32'd16);
    cyc(1'b0, 32'h0, 1'b0);
    chk("ovf_clear", 32'(bus.Overflow), 32'h0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 32'h0, 1'b1);

    // Underflow alone, then push+pop while empty.
    cyc(1'b0, 32'h0, 1'b1);
    chk("unf_pulse", 32'(bus.Underflow), 32'h1);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h1234_5678, 1'b1);
    chk("unf_push_count", 32'(bus.Count),     32'h1);
    chk("unf_push_pulse", 32'(bus.Underflow), 32'h1);
    chk("unf_push_data",  bus.Rd_Data,        32'h1234_5678);
    cyc(1'b0, 32'h0, 1'b1);

    // Push+pop while full: pop wins, push refused.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h0300 + 32'(i), 1'b0);
    cyc(1'b1, 32'hBAD0_0000, 1'b1);
    chk("full_pp_count", 32'(bus.Count),    32'd15);
    chk("full_pp_ovf",   32'(bus.Overflow), 32'h1);
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 32'h0, 1'b1);

    // Steady occupancy of 8 across pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h0100 + 32'(i), 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, {13'h1ABC, 2'b10, 16'(i), 1'b1}, 1'b1);
    chk("wrap_count", 32'(bus.Count), 32'd8);
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1);

    // Asynchronous reset with 5 words queued.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h0500 + 32'(i), 1'b0);
    bus.Wr_En = 1'b0;
    #3;
    Reset_n = 1'b0;
    #1;
    chk("async_empty", 32'(bus.Empty),    32'h1);
    chk("async_count", 32'(bus.Count),    32'h0);
    chk("async_data",  bus.Rd_Data,       32'h0);
    chk("async_full",  32'(bus.Full),     32'h0);
    exp_q.delete();
    mcnt = 0;
    bus.Wr_En = 1'b1;
    bus.Wr_Data = 32'hFFFF_FFFF;
    @(posedge Clk);
    #1;
    chk("rst_push_ignored", 32'(bus.Count), 32'h0);
    bus.Wr_En = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc(1'b1, 32'hA5A5_A5A5, 1'b0);
    chk("post_rst_data", bus.Rd_Data, 32'hA5A5_A5A5);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
